bn_stream_unit: RTL and testbench

- Multi-channel, pipelined successor to the combinational batch-normalization stage.
- Applies a per-channel shift-add scale and addend to streamed membrane values: u_out = sh1(u) + sh2(u) + addend.
- Coefficients live in an internal per-channel register bank written through a config port.
- Sits between the neuron membrane update and the threshold/spike stage; valid/ready on both sides.

---
 rtl/bn_stream_unit.sv | 171 +++++++++++++++++
 tb/tb_bn_stream_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/bn_stream_unit.sv
// Two-stage streaming batch-norm: u_out = sh1(u) + sh2(u) + addend, with a per-channel coefficient bank.
// Define BN_SATURATE_EN for full-precision sums clamped to 2^WIDTH-1 (default: modular WIDTH-bit arithmetic).
module bn_stream_unit #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int CH_BITS  = $clog2(CHANNELS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [CH_BITS-1:0] cfg_ch,
    input  logic [3:0]         cfg_factor,
    input  logic [WIDTH-1:0]   cfg_addend,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CH_BITS-1:0] in_ch,
    input  logic [WIDTH-1:0]   u_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CH_BITS-1:0] out_ch,
    output logic [WIDTH-1:0]   u_out
);

`ifdef BN_SATURATE_EN
    localparam int SUM_W = WIDTH + 4;
`else
    localparam int SUM_W = WIDTH;
`endif

    localparam logic [3:0] ID_FACTOR = 4'b0100;

    function automatic logic [SUM_W-1:0] sh1_term(input logic [1:0] code, input logic [WIDTH-1:0] u);
        logic [SUM_W-1:0] ux;
        ux = SUM_W'(u);
        case (code)
            2'b00:   return '0;
            2'b01:   return ux >> 1;
            2'b10:   return ux << 1;
            default: return ux << 3;
        endcase
    endfunction

    function automatic logic [SUM_W-1:0] sh2_term(input logic [1:0] code, input logic [WIDTH-1:0] u);
        logic [SUM_W-1:0] ux;
        ux = SUM_W'(u);
        case (code)
            2'b00:   return '0;
            2'b01:   return ux;
            2'b10:   return ux >> 2;
            default: return ux << 2;
        endcase
    endfunction

    logic [3:0]       bank_factor_q [CHANNELS];
    logic [3:0]       bank_factor_d [CHANNELS];
    logic [WIDTH-1:0] bank_addend_q [CHANNELS];
    logic [WIDTH-1:0] bank_addend_d [CHANNELS];

    logic               s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]   s1_u_q, s1_u_d;
    logic [CH_BITS-1:0] s1_ch_q, s1_ch_d;
    logic [3:0]         s1_factor_q, s1_factor_d;
    logic [WIDTH-1:0]   s1_addend_q, s1_addend_d;

    logic               out_valid_q, out_valid_d;
    logic [CH_BITS-1:0] out_ch_q, out_ch_d;
    logic [WIDTH-1:0]   u_out_q, u_out_d;

    logic               in_accept;
    logic               s1_adv;
    logic [3:0]         sel_factor;
    logic [WIDTH-1:0]   sel_addend;
    logic [SUM_W-1:0]   s1_sum;
    logic [WIDTH-1:0]   s2_result;

    assign s1_adv    = !out_valid_q || out_ready;
    assign in_ready  = !s1_valid_q || s1_adv;
    assign in_accept = in_valid && in_ready;

    // Channel decode by loop: indices at or beyond CHANNELS match nothing, so
    // such writes are dropped and such samples fall back to identity.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
        bank_factor_d = bank_factor_q;
        bank_addend_d = bank_addend_q;
        sel_factor    = ID_FACTOR;
        sel_addend    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_we && cfg_ch == CH_BITS'(i)) begin
                bank_factor_d[i] = cfg_factor;
                bank_addend_d[i] = cfg_addend;
            end
            if (in_ch == CH_BITS'(i)) begin
                sel_factor = bank_factor_q[i];
                sel_addend = bank_addend_q[i];
            end
        end
    end

    always_comb begin
        s1_valid_d  = in_accept ? 1'b1 : (s1_adv ? 1'b0 : s1_valid_q);
        s1_u_d      = s1_u_q;
        s1_ch_d     = s1_ch_q;
        s1_factor_d = s1_factor_q;
        s1_addend_d = s1_addend_q;
        if (in_accept) begin
            s1_u_d      = u_in;
            s1_ch_d     = in_ch;
            s1_factor_d = sel_factor;
            s1_addend_d = sel_addend;
        end
    end

    assign s1_sum = sh1_term(s1_factor_q[1:0], s1_u_q) + sh2_term(s1_factor_q[3:2], s1_u_q);

`ifdef BN_SATURATE_EN
    logic [SUM_W-1:0] s2_full;
    always_comb begin
        s2_full   = s1_sum + SUM_W'(s1_addend_q);
        s2_result = (|s2_full[SUM_W-1:WIDTH]) ? '1 : s2_full[WIDTH-1:0];
    end
`else
    assign s2_result = s1_sum + s1_addend_q;
`endif

    // Output register holds while stalled, so u_out/out_ch stay stable under backpressure.
    always_comb begin
        out_valid_d = s1_adv ? s1_valid_q : out_valid_q;
        out_ch_d    = out_ch_q;
        u_out_d     = u_out_q;
        if (s1_adv && s1_valid_q) begin
            out_ch_d = s1_ch_q;
            u_out_d  = s2_result;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the coefficient bank is flops with reset, not RAM, so every channel starts as identity.
            for (int i = 0; i < CHANNELS; i++) begin
                bank_factor_q[i] <= ID_FACTOR;
                bank_addend_q[i] <= '0;
            end
            s1_valid_q  <= 1'b0;
            s1_u_q      <= '0;
            s1_ch_q     <= '0;
            s1_factor_q <= ID_FACTOR;
            s1_addend_q <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            u_out_q     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops sample the same edge values.
            bank_factor_q <= bank_factor_d;
            bank_addend_q <= bank_addend_d;
            s1_valid_q    <= s1_valid_d;
            s1_u_q        <= s1_u_d;
            s1_ch_q       <= s1_ch_d;
            s1_factor_q   <= s1_factor_d;
            s1_addend_q   <= s1_addend_d;
            out_valid_q   <= out_valid_d;
            out_ch_q      <= out_ch_d;
            u_out_q       <= u_out_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign u_out     = u_out_q;

endmodule

// File: tb/tb_bn_stream_unit.sv
// Directed bench for bn_stream_unit: reset, coefficients, overflow, backpressure, write collision, mid-run reset.
module tb_bn_stream_unit;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int CH_BITS  = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               cfg_we = 1'b0;
    logic [CH_BITS-1:0] cfg_ch = '0;
    logic [3:0]         cfg_factor = '0;
    logic [WIDTH-1:0]   cfg_addend = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [CH_BITS-1:0] in_ch = '0;
    logic [WIDTH-1:0]   u_in = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [CH_BITS-1:0] out_ch;
    logic [WIDTH-1:0]   u_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bn_stream_unit #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_factor(cfg_factor), .cfg_addend(cfg_addend),
        .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .u_in(u_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .u_out(u_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // All tasks start and end just after a falling edge.
    task automatic write_cfg(input logic [CH_BITS-1:0] ch, input logic [3:0] f, input logic [WIDTH-1:0] a);
        cfg_we = 1'b1; cfg_ch = ch; cfg_factor = f; cfg_addend = a;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic send(input logic [CH_BITS-1:0] ch, input logic [WIDTH-1:0] u);
        bit accepted = 0;
        bit rdy;
        in_valid = 1'b1; in_ch = ch; u_in = u;
        for (int i = 0; i < 10 && !accepted; i++) begin
            rdy = in_ready;
            @(negedge clk);
            if (rdy) accepted = 1;
        end
        in_valid = 1'b0;
        if (!accepted) check("send_timeout", 0, 1);
    endtask

    task automatic expect_out(input string tag, input logic [CH_BITS-1:0] ch, input logic [WIDTH-1:0] u);
        int n = 0;
        while (!out_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_u"}, u_out, u);
        check({tag, "_ch"}, out_ch, ch);
        @(negedge clk);
    endtask

    initial begin
        int accepted;
        int stale;
        logic [WIDTH-1:0] next_u;
        logic [WIDTH-1:0] ovf_exp;

        // Reset defaults and identity path with exact latency.
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_u_out", u_out, 0);
        check("rst_out_ch", out_ch, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        send(2, 37);
        check("lat_valid_early", out_valid, 0);
        check("lat_u_early", u_out, 0);
        @(negedge clk);
        check("lat_valid", out_valid, 1);
        check("lat_u", u_out, 37);
        check("lat_ch", out_ch, 2);
        @(negedge clk);

        // Coefficient path: (20<<1) + 20 + 5.
        write_cfg(1, 4'b0110, 5);
        send(1, 20);
        expect_out("coef", 1, 65);

        // Overflow: (200<<3) + 200.
`ifdef BN_SATURATE_EN
        ovf_exp = 8'd255;
`else
        ovf_exp = 8'd8;
`endif
        write_cfg(0, 4'b0111, 0);
        send(0, 200);
        expect_out("ovf", 0, ovf_exp);
        write_cfg(0, 4'b0100, 0);

        // Backpressure: only two samples fit while the output is stalled.
        out_ready = 1'b0;
        accepted = 0;
        next_u = 1;
        in_valid = 1'b1; in_ch = 0; u_in = next_u;
        for (int c = 0; c < 4; c++) begin
            bit rdy;
            rdy = in_ready;
            @(negedge clk);
            if (rdy) begin
                accepted++;
                next_u++;
                u_in = next_u;
            end
            if (c >= 1) check("bp_hold_u", u_out, 1);
        end
        check("bp_accepted", accepted, 2);
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        out_ready = 1'b1;
        check("bp_drain1", u_out, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_drain2_v", out_valid, 1);
        check("bp_drain2", u_out, 2);
        @(negedge clk);
        check("bp_drain3_v", out_valid, 1);
        check("bp_drain3", u_out, 3);
        @(negedge clk);
        check("bp_empty", out_valid, 0);

        // Write collision: first sample keeps old coefficients, second sees (6<<2)+10.
        cfg_we = 1'b1; cfg_ch = 3; cfg_factor = 4'b1100; cfg_addend = 10;
        in_valid = 1'b1; in_ch = 3; u_in = 6;
        check("coll_rdy0", in_ready, 1);
        @(negedge clk);
        cfg_we = 1'b0;
        check("coll_rdy1", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        expect_out("coll_old", 3, 6);
        expect_out("coll_new", 3, 34);

        // Mid-operation reset with two samples in flight.
        write_cfg(2, 4'b1001, 3);
        out_ready = 1'b0;
        send(2, 8);
        send(2, 12);
        check("mid_inflight", out_valid, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_u", u_out, 0);
        check("mid_rst_ready", in_ready, 1);
        rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("mid_stale", stale, 0);
        send(2, 40);
        expect_out("mid_id_ch2", 2, 40);
        send(3, 6);
        expect_out("mid_id_ch3", 3, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
        $finish;
    end

endmodule
